inst_fetch_ctrl: RTL and testbench

Responder side of the PC fetch interface. Consumes the fetch address `pc` and enable `ce` produced by the PC register. Reads the 32-bit instruction from a byte-wide, 1-cycle-latency instruction memory as four sequential byte reads, then presents it to the IF/ID stage. While a fetch is in flight it raises `stall_req` to the stall controller, which holds `stall[0]` so the PC stays put. It aborts cleanly on a branch flush.

---
 rtl/inst_fetch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch responder: assembles a 32-bit instruction from four
// sequential byte reads of a 1-cycle-latency memory, holding the PC via stall_req.
module inst_fetch_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  input  logic [7:0]        mem_din,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_rd,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  output logic              stall_req
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RD3  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] fetch_pc_r, fetch_pc_s;
  logic [ADDR_W-1:0] mem_a_r, mem_a_s;
  logic [ADDR_W-1:0] inst_pc_r, inst_pc_s;
  logic              mem_rd_r, mem_rd_s;
  logic              inst_valid_r, inst_valid_s;
  logic [7:0]        b0_r, b0_s;
  logic [7:0]        b1_r, b1_s;
  logic [7:0]        b2_r, b2_s;
  logic [31:0]       inst_r, inst_s;
  logic              abort_s;

  // Fetch sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and next datapath values; a flush or dropped ce aborts any fetch in flight
  always_comb begin
    state_s      = state_r;
    fetch_pc_s   = fetch_pc_r;
    mem_a_s      = mem_a_r;
    mem_rd_s     = mem_rd_r;
    b0_s         = b0_r;
    b1_s         = b1_r;
    b2_s         = b2_r;
    inst_s       = inst_r;
    inst_pc_s    = inst_pc_r;
    inst_valid_s = 1'b0;
    abort_s      = flush | ~ce;

    case (state_r)
      IDLE: begin
        if (!abort_s) begin
          fetch_pc_s = pc;
          mem_a_s    = pc;
          mem_rd_s   = 1'b1;
          state_s    = RD0;
        end else begin
          mem_rd_s   = 1'b0;
          state_s    = IDLE;
        end
      end
      RD0: begin
        if (abort_s) begin
          mem_rd_s = 1'b0;
          state_s  = IDLE;
        end else begin
          mem_a_s  = fetch_pc_r + ADDR_W'(1);
          state_s  = RD1;
        end
      end
      RD1: begin
        if (abort_s) begin
          mem_rd_s = 1'b0;
          state_s  = IDLE;
        end else begin
          b0_s     = mem_din;
          mem_a_s  = fetch_pc_r + ADDR_W'(2);
          state_s  = RD2;
        end
      end
      RD2: begin
        if (abort_s) begin
          mem_rd_s = 1'b0;
          state_s  = IDLE;
        end else begin
          b1_s     = mem_din;
          mem_a_s  = fetch_pc_r + ADDR_W'(3);
          state_s  = RD3;
        end
      end
      RD3: begin
        if (abort_s) begin
          mem_rd_s = 1'b0;
          state_s  = IDLE;
        end else begin
          b2_s     = mem_din;
          mem_rd_s = 1'b0;
          state_s  = DONE;
        end
      end
      DONE: begin
        // The last byte arrives this cycle, so it goes straight into inst
        if (abort_s) begin
          mem_rd_s     = 1'b0;
          state_s      = IDLE;
        end else begin
          inst_s       = {mem_din, b2_r, b1_r, b0_r};
          inst_pc_s    = fetch_pc_r;
          inst_valid_s = 1'b1;
          state_s      = IDLE;
        end
      end
      default: begin
        mem_rd_s = 1'b0;
        state_s  = IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r   <= {ADDR_W{1'b0}};
      mem_a_r      <= {ADDR_W{1'b0}};
      mem_rd_r     <= 1'b0;
      b0_r         <= 8'h00;
      b1_r         <= 8'h00;
      b2_r         <= 8'h00;
      inst_r       <= 32'h0000_0000;
      inst_pc_r    <= {ADDR_W{1'b0}};
      inst_valid_r <= 1'b0;
    end else begin
      fetch_pc_r   <= fetch_pc_s;
      mem_a_r      <= mem_a_s;
      mem_rd_r     <= mem_rd_s;
      b0_r         <= b0_s;
      b1_r         <= b1_s;
      b2_r         <= b2_s;
      inst_r       <= inst_s;
      inst_pc_r    <= inst_pc_s;
      inst_valid_r <= inst_valid_s;
    end
  end

  // Dropping in DONE lets the PC advance on the same edge the instruction completes
  assign stall_req  = ce & ~flush & ~rst & (state_r != DONE);

  assign mem_a      = mem_a_r;
  assign mem_rd     = mem_rd_r;
  assign inst       = inst_r;
  assign inst_pc    = inst_pc_r;
  assign inst_valid = inst_valid_r;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: table-driven single fetches plus
// hand-written PC-model sequences for flush, reset and abort corner cases.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        flush;
  logic [31:0] pc;
  logic [7:0]  mem_din;
  logic [31:0] mem_a;
  logic        mem_rd;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        stall_req;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [256];

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  d0, d1, d2, d3;
    logic [31:0] exp_inst;
  } vec_t;
  vec_t tv [5];

  int          pulse_cyc  [$];
  logic [31:0] pulse_pc   [$];
  logic [31:0] pulse_inst [$];
  logic        stall_log  [32];

  always #5 clk = ~clk;

  inst_fetch_ctrl #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .pc         (pc),
    .flush      (flush),
    .mem_din    (mem_din),
    .mem_a      (mem_a),
    .mem_rd     (mem_rd),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .stall_req  (stall_req)
  );

  // Byte memory with one cycle of read latency, decoded on the low address byte
  always @(posedge clk) begin
    if (mem_rd) mem_din <= mem[mem_a[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ce = 1'b0; flush = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  // Runs the DUT against a PC register that advances by 4 whenever stall_req is low
  task automatic pc_run(input int ncyc, input int flush_cyc, input logic [31:0] tgt);
    logic [31:0] nxt;
    nxt = pc;
    pulse_cyc.delete(); pulse_pc.delete(); pulse_inst.delete();
    for (int c = 0; c < ncyc; c++) begin
      pc    = nxt;
      flush = (c == flush_cyc);
      #1;
      if (inst_valid) begin
        pulse_cyc.push_back(c);
        pulse_pc.push_back(inst_pc);
        pulse_inst.push_back(inst);
      end
      stall_log[c] = stall_req;
      if (flush)           nxt = tgt;
      else if (!stall_req) nxt = pc + 32'd4;
      else                 nxt = pc;
      step();
    end
    flush = 1'b0;
  endtask

  initial begin
    logic [31:0] ea;
    logic [7:0]  idx;

    tv[0] = '{pc: 32'h0000_0000, d0: 8'h13, d1: 8'h05, d2: 8'h50, d3: 8'h00, exp_inst: 32'h0050_0513};
    tv[1] = '{pc: 32'h0000_0004, d0: 8'h93, d1: 8'h05, d2: 8'h10, d3: 8'h00, exp_inst: 32'h0010_0593};
    tv[2] = '{pc: 32'h0000_0040, d0: 8'hB3, d1: 8'h05, d2: 8'hB5, d3: 8'h00, exp_inst: 32'h00B5_05B3};
    tv[3] = '{pc: 32'hFFFF_FFFC, d0: 8'hDE, d1: 8'hAD, d2: 8'hBE, d3: 8'hEF, exp_inst: 32'hEFBE_ADDE};
    tv[4] = '{pc: 32'h0000_0080, d0: 8'h78, d1: 8'h56, d2: 8'h34, d3: 8'h12, exp_inst: 32'h1234_5678};

    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      idx = tv[i].pc[7:0];
      mem[idx]         = tv[i].d0;
      mem[idx + 8'd1]  = tv[i].d1;
      mem[idx + 8'd2]  = tv[i].d2;
      mem[idx + 8'd3]  = tv[i].d3;
    end

    // Reset state, with ce high to show stall_req is masked by rst
    rst = 1'b1; ce = 1'b1; flush = 1'b0; pc = 32'h0000_0010;
    step();
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    #1;
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    rst = 1'b0; ce = 1'b0;
    step();

    // Table of isolated fetches
    for (int i = 0; i < 5; i++) begin
      pc = tv[i].pc; ce = 1'b1; flush = 1'b0;
      #1;
      chk($sformatf("tbl%0d_stall_c0", i), {31'd0, stall_req}, 32'd1);
      for (int c = 1; c <= 5; c++) begin
        step();
        if (c <= 4) begin
          ea = tv[i].pc + 32'(c - 1);
          chk($sformatf("tbl%0d_mem_a_c%0d", i, c), mem_a, ea);
          chk($sformatf("tbl%0d_mem_rd_c%0d", i, c), {31'd0, mem_rd}, 32'd1);
        end else begin
          chk($sformatf("tbl%0d_mem_rd_done", i), {31'd0, mem_rd}, 32'd0);
        end
        chk($sformatf("tbl%0d_valid_low_c%0d", i, c), {31'd0, inst_valid}, 32'd0);
        #1;
        chk($sformatf("tbl%0d_stall_c%0d", i, c), {31'd0, stall_req}, (c <= 4) ? 32'd1 : 32'd0);
      end
      step();
      chk($sformatf("tbl%0d_valid", i), {31'd0, inst_valid}, 32'd1);
      chk($sformatf("tbl%0d_inst", i), inst, tv[i].exp_inst);
      chk($sformatf("tbl%0d_inst_pc", i), inst_pc, tv[i].pc);
      ce = 1'b0;
      step();
      chk($sformatf("tbl%0d_valid_drop", i), {31'd0, inst_valid}, 32'd0);
      chk($sformatf("tbl%0d_inst_hold", i), inst, tv[i].exp_inst);
    end

    // Reset asserted in RD1
    pc = 32'h0000_0040; ce = 1'b1;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rstmid_stall", {31'd0, stall_req}, 32'd0);
    step();
    rst = 1'b0; ce = 1'b0;
    chk("rstmid_mem_a", mem_a, 32'h0);
    chk("rstmid_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rstmid_inst", inst, 32'h0);
    chk("rstmid_inst_pc", inst_pc, 32'h0);
    chk("rstmid_valid", {31'd0, inst_valid}, 32'd0);
    for (int c = 0; c < 7; c++) begin
      step();
      chk($sformatf("rstmid_quiet%0d", c), {30'd0, inst_valid, mem_rd}, 32'd0);
    end

    // Back-to-back fetches with the PC model
    do_reset();
    ce = 1'b1; pc = 32'h0;
    pc_run(14, -1, 32'h0);
    chk("seq_npulse", pulse_cyc.size(), 32'd2);
    chk("seq_stall_c4", {31'd0, stall_log[4]}, 32'd1);
    chk("seq_stall_c5", {31'd0, stall_log[5]}, 32'd0);
    chk("seq_stall_c11", {31'd0, stall_log[11]}, 32'd0);
    if (pulse_cyc.size() >= 2) begin
      chk("seq_p0_cyc", pulse_cyc[0], 32'd6);
      chk("seq_p0_inst", pulse_inst[0], 32'h0050_0513);
      chk("seq_p1_cyc", pulse_cyc[1], 32'd12);
      chk("seq_p1_pc", pulse_pc[1], 32'h4);
      chk("seq_p1_inst", pulse_inst[1], 32'h0010_0593);
    end

    // Flush in RD2, PC loads 0x40
    do_reset();
    ce = 1'b1; pc = 32'h0;
    pc_run(12, 3, 32'h0000_0040);
    chk("fl_npulse", pulse_cyc.size(), 32'd1);
    chk("fl_stall_c2", {31'd0, stall_log[2]}, 32'd1);
    chk("fl_stall_c3", {31'd0, stall_log[3]}, 32'd0);
    if (pulse_cyc.size() >= 1) begin
      chk("fl_cyc", pulse_cyc[0], 32'd10);
      chk("fl_pc", pulse_pc[0], 32'h40);
      chk("fl_inst", pulse_inst[0], 32'h00B5_05B3);
    end

    // Flush in DONE, PC loads 0x80
    do_reset();
    ce = 1'b1; pc = 32'h0;
    pc_run(14, 5, 32'h0000_0080);
    chk("fldone_npulse", pulse_cyc.size(), 32'd1);
    if (pulse_cyc.size() >= 1) begin
      chk("fldone_cyc", pulse_cyc[0], 32'd12);
      chk("fldone_pc", pulse_pc[0], 32'h80);
      chk("fldone_inst", pulse_inst[0], 32'h1234_5678);
    end

    // ce dropped in RD1 aborts, then a fresh fetch completes
    do_reset();
    ce = 1'b1; pc = 32'h0;
    step();
    step();
    ce = 1'b0;
    step();
    chk("ceab_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("ceab_mem_a", mem_a, 32'h1);
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("ceab_quiet%0d", c), {31'd0, inst_valid}, 32'd0);
    end
    ce = 1'b1; pc = 32'h4;
    for (int c = 0; c < 6; c++) step();
    chk("ceab_valid", {31'd0, inst_valid}, 32'd1);
    chk("ceab_inst_pc", inst_pc, 32'h4);
    chk("ceab_inst", inst, 32'h0010_0593);
    ce = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
